cluster_evt_dc_sink: RTL and testbench

//  Receive-side (cluster clock) half of the token-based dual-clock event bus that carries SoC events to the cluster.
//  - Synchronises the write-token vector from the SoC side.
//  - Drains slots strictly in ring order into a registered valid/ready stream for the cluster event unit.
//  - Returns a read-pointer toggle vector so the source can reuse freed slots.

---
 rtl/cluster_evt_pkg.sv | 11 +
 rtl/evt_token_sync.sv | 34 +++
 rtl/cluster_evt_dc_sink.sv | 124 ++++++++++++
 tb/tb_cluster_evt_dc_sink.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cluster_evt_pkg.sv
// Shared types and default sizing for the cluster-side event sink of the dual-clock event bus.
package cluster_evt_pkg;

    localparam int DEF_BUFFER_WIDTH = 8;
    localparam int DEF_EVNT_WIDTH   = 8;
    localparam int DEF_SYNC_STAGES  = 2;
    localparam int IDX_W            = $clog2(DEF_BUFFER_WIDTH);

    typedef logic [DEF_EVNT_WIDTH-1:0] evt_t;

endpackage

// File: rtl/evt_token_sync.sv
// Multi-stage flop bank that brings the SoC-side write-token vector into the cluster clock domain.
// This is the only clock-domain crossing cell of the event sink.
module evt_token_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [STAGES-1:0][WIDTH-1:0] sync_q;
    logic [STAGES-1:0][WIDTH-1:0] sync_d;

    always_comb begin
        sync_d[0] = d_i;
        for (int s = 1; s < STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every stage samples the pre-edge value of its neighbour.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cluster_evt_dc_sink.sv
// Cluster-clock receive half of the token-based dual-clock event bus: drains slots in ring order.
// Optional statistics (evt_cnt_o, ovf_o) are built when CLUSTER_EVT_SINK_STATS_EN is defined.
module cluster_evt_dc_sink
    import cluster_evt_pkg::*;
#(
    parameter int BUFFER_WIDTH = DEF_BUFFER_WIDTH,
    parameter int EVNT_WIDTH   = DEF_EVNT_WIDTH,
    parameter int SYNC_STAGES  = DEF_SYNC_STAGES
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [BUFFER_WIDTH-1:0]          wt_i,
    input  logic [BUFFER_WIDTH*EVNT_WIDTH-1:0] da_i,
    output logic [BUFFER_WIDTH-1:0]          rp_o,
    output logic                             evt_valid_o,
    output logic [EVNT_WIDTH-1:0]            evt_data_o,
    input  logic                             evt_ready_i,
    output logic                             busy_o
`ifdef CLUSTER_EVT_SINK_STATS_EN
    ,
    output logic [15:0]                      evt_cnt_o,
    output logic                             ovf_o
`endif
);

    localparam int RD_IDX_W = (BUFFER_WIDTH > 1) ? $clog2(BUFFER_WIDTH) : 1;
    localparam logic [RD_IDX_W-1:0] LAST_IDX = RD_IDX_W'(BUFFER_WIDTH - 1);

    logic [BUFFER_WIDTH-1:0] wt_s;
    logic [BUFFER_WIDTH-1:0] rp_q, rp_d;
    logic [RD_IDX_W-1:0]     rd_idx_q, rd_idx_d;
    logic                    evt_valid_q, evt_valid_d;
    logic [EVNT_WIDTH-1:0]   evt_data_q, evt_data_d;
    logic                    pending;
    logic                    load;

    evt_token_sync #(
        .WIDTH  (BUFFER_WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_token_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (wt_i),
        .q_o   (wt_s)
    );

    // Parity per slot: a slot holds an unread event while its token and read bit differ.
    always_comb begin
        // NOTE: every combinational output is defaulted first so no path leaves it unassigned (no latch).
        rp_d        = rp_q;
        rd_idx_d    = rd_idx_q;
        evt_valid_d = evt_valid_q;
        evt_data_d  = evt_data_q;

        pending = wt_s[rd_idx_q] ^ rp_q[rd_idx_q];
        load    = pending & (~evt_valid_q | evt_ready_i);

        if (load) begin
            evt_data_d         = da_i[int'(rd_idx_q) * EVNT_WIDTH +: EVNT_WIDTH];
            evt_valid_d        = 1'b1;
            rp_d[rd_idx_q]     = ~rp_q[rd_idx_q];
            rd_idx_d           = (rd_idx_q == LAST_IDX) ? '0 : rd_idx_q + RD_IDX_W'(1);
        end else if (evt_ready_i) begin
            evt_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rp_q        <= '0;
            rd_idx_q    <= '0;
            evt_valid_q <= 1'b0;
            evt_data_q  <= '0;
        end else begin
            rp_q        <= rp_d;
            rd_idx_q    <= rd_idx_d;
            evt_valid_q <= evt_valid_d;
            evt_data_q  <= evt_data_d;
        end
    end

    assign rp_o        = rp_q;
    assign evt_valid_o = evt_valid_q;
    assign evt_data_o  = evt_data_q;
    assign busy_o      = (|(wt_s ^ rp_q)) | evt_valid_q;

`ifdef CLUSTER_EVT_SINK_STATS_EN
    logic [BUFFER_WIDTH-1:0] wt_prev_q;
    logic [15:0]             evt_cnt_q, evt_cnt_d;
    logic                    ovf_q, ovf_d;

    // A token that flips again while its slot is still unread means the source overwrote it.
    always_comb begin
        evt_cnt_d = evt_cnt_q;
        if (evt_valid_q && evt_ready_i && (evt_cnt_q != 16'hFFFF)) begin
            evt_cnt_d = evt_cnt_q + 16'd1;
        end
        ovf_d = ovf_q | (|((wt_s ^ wt_prev_q) & (wt_prev_q ^ rp_q)));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wt_prev_q <= '0;
            evt_cnt_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            wt_prev_q <= wt_s;
            evt_cnt_q <= evt_cnt_d;
            ovf_q     <= ovf_d;
        end
    end

    assign evt_cnt_o = evt_cnt_q;
    assign ovf_o     = ovf_q;
`endif

`ifndef SYNTHESIS
    a_no_double_write : assert property (
        @(posedge clk_i) disable iff (rst_i)
        ((wt_s ^ $past(wt_s)) & ($past(wt_s) ^ $past(rp_q))) == '0
    ) else $error("slot token toggled while slot still pending");
`endif

endmodule

// File: tb/tb_cluster_evt_dc_sink.sv
// Directed self-checking bench for cluster_evt_dc_sink (8 slots, 8-bit events, 2 sync stages).
module tb_cluster_evt_dc_sink;
    import cluster_evt_pkg::*;

    logic        clk;
    logic        rst;
    logic [7:0]  wt;
    logic [63:0] da;
    logic [7:0]  rp;
    logic        evt_valid;
    logic [7:0]  evt_data;
    logic        evt_ready;
    logic        busy;
`ifdef CLUSTER_EVT_SINK_STATS_EN
    logic [15:0] evt_cnt;
    logic        ovf;
`endif

    int n_chk = 0;
    int n_bad = 0;

    cluster_evt_dc_sink #(
        .BUFFER_WIDTH (8),
        .EVNT_WIDTH   (8),
        .SYNC_STAGES  (2)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .wt_i        (wt),
        .da_i        (da),
        .rp_o        (rp),
        .evt_valid_o (evt_valid),
        .evt_data_o  (evt_data),
        .evt_ready_i (evt_ready),
        .busy_o      (busy)
`ifdef CLUSTER_EVT_SINK_STATS_EN
        ,
        .evt_cnt_o   (evt_cnt),
        .ovf_o       (ovf)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (!evt_valid && n < budget) begin
            step();
            n++;
        end
        check(tag, {31'd0, evt_valid}, 32'd1);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        wt        = '0;
        da        = '0;
        evt_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic put(input int slot, input evt_t val);
        da[slot*8 +: 8] = val;
        wt[slot]        = ~wt[slot];
    endtask

    initial begin
        rst       = 1'b1;
        wt        = '0;
        da        = '0;
        evt_ready = 1'b0;

        // 1. reset with random source activity
        wt = 8'($urandom);
        da = {$urandom, $urandom};
        step();
        step();
        step();
        check("rst_rp",    {24'd0, rp}, 32'h00);
        check("rst_valid", {31'd0, evt_valid}, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_data",  {24'd0, evt_data}, 32'h00);
        wt = '0;
        step();
        rst = 1'b0;
        step();
        step();
        step();
        check("post_rst_rp",    {24'd0, rp}, 32'h00);
        check("post_rst_valid", {31'd0, evt_valid}, 32'd0);
        check("post_rst_busy",  {31'd0, busy}, 32'd0);

        // 2. single event latency
        do_reset();
        evt_ready = 1'b1;
        put(0, 8'hA5);
        step();
        step();
        check("single_early_valid", {31'd0, evt_valid}, 32'd0);
        step();
        check("single_valid", {31'd0, evt_valid}, 32'd1);
        check("single_data",  {24'd0, evt_data}, 32'hA5);
        check("single_rp",    {24'd0, rp}, 32'h01);
        check("single_busy",  {31'd0, busy}, 32'd1);
        step();
        check("single_drop", {31'd0, evt_valid}, 32'd0);
        check("single_idle", {31'd0, busy}, 32'd0);

        // 3. backpressure on a full ring, then back-to-back drain
        do_reset();
        for (int i = 0; i < 8; i++) begin
            put(i, evt_t'(8'h10 + i));
        end
        step();
        step();
        step();
        check("bp_valid", {31'd0, evt_valid}, 32'd1);
        check("bp_data",  {24'd0, evt_data}, 32'h10);
        check("bp_rp",    {24'd0, rp}, 32'h01);
        for (int i = 0; i < 4; i++) begin
            step();
        end
        check("bp_hold_data", {24'd0, evt_data}, 32'h10);
        check("bp_hold_rp",   {24'd0, rp}, 32'h01);
        check("bp_hold_busy", {31'd0, busy}, 32'd1);
        evt_ready = 1'b1;
        for (int k = 1; k < 8; k++) begin
            step();
            check($sformatf("drain_data_%0d", k), {24'd0, evt_data}, 32'h10 + k);
            check($sformatf("drain_valid_%0d", k), {31'd0, evt_valid}, 32'd1);
        end
        check("drain_rp", {24'd0, rp}, 32'hFF);
        step();
        check("drain_end_valid", {31'd0, evt_valid}, 32'd0);
        check("drain_end_busy",  {31'd0, busy}, 32'd0);

        // 4. wrap-around over ten events
        do_reset();
        evt_ready = 1'b1;
        for (int e = 0; e < 10; e++) begin
            put(e % 8, evt_t'(8'h20 + e));
            wait_valid($sformatf("wrap_wait_%0d", e), 10);
            check($sformatf("wrap_data_%0d", e), {24'd0, evt_data}, 32'h20 + e);
            step();
        end
        check("wrap_rp",    {24'd0, rp}, 32'hFC);
        check("wrap_valid", {31'd0, evt_valid}, 32'd0);

        // 5. reset in the middle of a burst
        do_reset();
        evt_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            put(i, evt_t'(8'h30 + i));
        end
        wait_valid("mid_wait", 10);
        check("mid_d0", {24'd0, evt_data}, 32'h30);
        step();
        check("mid_d1", {24'd0, evt_data}, 32'h31);
        step();
        check("mid_d2", {24'd0, evt_data}, 32'h32);
        step();
        check("mid_d3", {24'd0, evt_data}, 32'h33);
        rst = 1'b1;
        wt  = '0;
        da  = '0;
        #1;
        check("mid_rst_valid", {31'd0, evt_valid}, 32'd0);
        check("mid_rst_rp",    {24'd0, rp}, 32'h00);
        check("mid_rst_data",  {24'd0, evt_data}, 32'h00);
        check("mid_rst_busy",  {31'd0, busy}, 32'd0);
        step();
        rst = 1'b0;
        step();
        step();
        check("mid_after_busy", {31'd0, busy}, 32'd0);
        put(0, 8'h40);
        wait_valid("mid_new_wait", 10);
        check("mid_new_data", {24'd0, evt_data}, 32'h40);
        check("mid_new_rp",   {24'd0, rp}, 32'h01);
        step();

`ifdef CLUSTER_EVT_SINK_STATS_EN
        // 6. statistics: handshake count and sticky overflow
        do_reset();
        evt_ready = 1'b1;
        for (int e = 0; e < 5; e++) begin
            put(e, evt_t'(8'h50 + e));
            wait_valid($sformatf("stat_wait_%0d", e), 10);
            step();
        end
        check("stat_cnt", {16'd0, evt_cnt}, 32'd5);
        check("stat_ovf_clear", {31'd0, ovf}, 32'd0);
        evt_ready = 1'b0;
        put(5, 8'h60);
        put(6, 8'h61);
        for (int i = 0; i < 4; i++) begin
            step();
        end
        check("stat_ovf_single", {31'd0, ovf}, 32'd0);
        wt[6] = ~wt[6];
        for (int i = 0; i < 4; i++) begin
            step();
        end
        check("stat_ovf_set", {31'd0, ovf}, 32'd1);
        wt[6] = ~wt[6];
        for (int i = 0; i < 3; i++) begin
            step();
        end
        check("stat_ovf_sticky", {31'd0, ovf}, 32'd1);
        do_reset();
        check("stat_ovf_rst", {31'd0, ovf}, 32'd0);
        check("stat_cnt_rst", {16'd0, evt_cnt}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
